// File: rtl/em_pipe_reg.sv
// rtl/em_pipe_reg.sv - E/M pipeline register with Tnew tracking, stall/flush and forwarding qualifier
// Optional bubble counter enabled by defining EM_BUBBLE_CNT_EN.
module em_pipe_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_ans,
    input  logic [31:0] E_rt_data,
    input  logic [31:0] E_GRF_Wdata,
    input  logic [4:0]  E_GRF_A3,
    input  logic [1:0]  E_Tnew,
    output logic [31:0] M_pc,
    output logic [31:0] M_instr,
    output logic [31:0] M_ans,
    output logic [31:0] M_rt_data,
    output logic [31:0] M_GRF_Wdata,
    output logic [4:0]  M_GRF_A3,
    output logic [1:0]  M_Tnew,
    output logic        M_fwd_valid,
    output logic        M_bubble,
    output logic [31:0] M_bubble_cnt
);

    logic [1:0] tnew_next;

    // One cycle of latency is consumed crossing E->M; saturate at zero.
    assign tnew_next = (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            M_pc        <= RESET_PC;
            M_instr     <= 32'h0;
            M_ans       <= 32'h0;
            M_rt_data   <= 32'h0;
            M_GRF_Wdata <= 32'h0;
            M_GRF_A3    <= 5'd0;
            M_Tnew      <= 2'd0;
            M_bubble    <= 1'b1;
        end else if (flush) begin
            M_pc        <= 32'h0;
            M_instr     <= 32'h0;
            M_ans       <= 32'h0;
            M_rt_data   <= 32'h0;
            M_GRF_Wdata <= 32'h0;
            M_GRF_A3    <= 5'd0;
            M_Tnew      <= 2'd0;
            M_bubble    <= 1'b1;
        end else if (en) begin
            M_pc        <= E_pc;
            M_instr     <= E_instr;
            M_ans       <= E_ans;
            M_rt_data   <= E_rt_data;
            M_GRF_Wdata <= E_GRF_Wdata;
            M_GRF_A3    <= E_GRF_A3;
            M_Tnew      <= tnew_next;
            M_bubble    <= 1'b0;
        end
    end

    // Derived only from registers so it never glitches on E-stage inputs.
    assign M_fwd_valid = (M_GRF_A3 != 5'd0) && (M_Tnew == 2'd0) && !M_bubble;

`ifdef EM_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= 32'h0;
        end else if (flush && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign M_bubble_cnt = bubble_cnt;
`else
    assign M_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_em_pipe_reg.sv
// tb/tb_em_pipe_reg.sv - randomized self-checking bench for em_pipe_reg against a behavioural model
// Bubble-count expectations follow EM_BUBBLE_CNT_EN.
module tb_em_pipe_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] E_pc = 32'h0, E_instr = 32'h0, E_ans = 32'h0, E_rt_data = 32'h0, E_GRF_Wdata = 32'h0;
    logic [4:0]  E_GRF_A3 = 5'd0;
    logic [1:0]  E_Tnew = 2'd0;
    logic [31:0] M_pc, M_instr, M_ans, M_rt_data, M_GRF_Wdata, M_bubble_cnt;
    logic [4:0]  M_GRF_A3;
    logic [1:0]  M_Tnew;
    logic        M_fwd_valid, M_bubble;

    int checks = 0;
    int failures = 0;

    // Reference state: what the M stage should be holding.
    logic [31:0] r_pc, r_instr, r_ans, r_rt, r_wd;
    int          r_a3, r_tnew, r_bubble;
    longint      r_cnt;

    em_pipe_reg #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .E_pc(E_pc), .E_instr(E_instr), .E_ans(E_ans), .E_rt_data(E_rt_data),
        .E_GRF_Wdata(E_GRF_Wdata), .E_GRF_A3(E_GRF_A3), .E_Tnew(E_Tnew),
        .M_pc(M_pc), .M_instr(M_instr), .M_ans(M_ans), .M_rt_data(M_rt_data),
        .M_GRF_Wdata(M_GRF_Wdata), .M_GRF_A3(M_GRF_A3), .M_Tnew(M_Tnew),
        .M_fwd_valid(M_fwd_valid), .M_bubble(M_bubble), .M_bubble_cnt(M_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        r_pc = 32'h0000_3000; r_instr = 0; r_ans = 0; r_rt = 0; r_wd = 0;
        r_a3 = 0; r_tnew = 0; r_bubble = 1; r_cnt = 0;
    endtask

    task automatic model_edge();
        if (flush) begin
            r_pc = 0; r_instr = 0; r_ans = 0; r_rt = 0; r_wd = 0;
            r_a3 = 0; r_tnew = 0; r_bubble = 1;
`ifdef EM_BUBBLE_CNT_EN
            if (r_cnt < 64'hFFFF_FFFF) r_cnt = r_cnt + 1;
`endif
        end else if (en) begin
            r_pc = E_pc; r_instr = E_instr; r_ans = E_ans; r_rt = E_rt_data; r_wd = E_GRF_Wdata;
            r_a3 = int'(E_GRF_A3);
            r_tnew = (int'(E_Tnew) > 0) ? int'(E_Tnew) - 1 : 0;
            r_bubble = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        int fwd;
        fwd = (r_a3 != 0 && r_tnew == 0 && r_bubble == 0) ? 1 : 0;
        check_eq({ctx, ".pc"}, M_pc, r_pc);
        check_eq({ctx, ".instr"}, M_instr, r_instr);
        check_eq({ctx, ".ans"}, M_ans, r_ans);
        check_eq({ctx, ".rt"}, M_rt_data, r_rt);
        check_eq({ctx, ".wdata"}, M_GRF_Wdata, r_wd);
        check_eq({ctx, ".a3"}, {27'd0, M_GRF_A3}, r_a3);
        check_eq({ctx, ".tnew"}, {30'd0, M_Tnew}, r_tnew);
        check_eq({ctx, ".bubble"}, {31'd0, M_bubble}, r_bubble);
        check_eq({ctx, ".fwd"}, {31'd0, M_fwd_valid}, fwd);
        check_eq({ctx, ".cnt"}, M_bubble_cnt, r_cnt[31:0]);
    endtask

    // Clock an edge with the currently driven inputs, then compare.
    task automatic step(input string ctx);
        @(posedge clk);
        #1;
        model_edge();
        check_all(ctx);
    endtask

    task automatic drive_random();
        E_pc = $urandom; E_instr = $urandom; E_ans = $urandom;
        E_rt_data = $urandom; E_GRF_Wdata = $urandom;
        E_GRF_A3 = 5'($urandom_range(0, 31));
        E_Tnew = 2'($urandom_range(0, 3));
    endtask

    // Assert reset between edges and expect reset values without a clock edge.
    task automatic async_reset(input string ctx);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        #1 reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        async_reset("rst");
        check_eq("rst.pc_const", M_pc, 32'h0000_3000);

        // Normal load, forwardable.
        en = 1; flush = 0;
        E_pc = 32'h0000_3008; E_instr = 32'h0123_4567; E_ans = 32'h10;
        E_rt_data = 32'h20; E_GRF_Wdata = 32'h0000_300C; E_GRF_A3 = 5'd31; E_Tnew = 2'd0;
        step("load");
        check_eq("load.fwd_const", {31'd0, M_fwd_valid}, 32'd1);

        // lw-style latency then saturation at zero.
        E_Tnew = 2'd2; step("tnew2");
        check_eq("tnew2.const", {30'd0, M_Tnew}, 32'd1);
        E_Tnew = 2'd3; step("tnew3");
        E_Tnew = 2'd0; step("tnew0");
        check_eq("tnew0.const", {30'd0, M_Tnew}, 32'd0);

        // Stall with changing inputs.
        E_ans = 32'h1234_5678; E_Tnew = 2'd2; step("preload");
        en = 0;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step("stall");
        end
        check_eq("stall.ans_const", M_ans, 32'h1234_5678);

        // Destination $0 never forwards.
        en = 1; E_GRF_A3 = 5'd0; E_Tnew = 2'd0; E_GRF_Wdata = 32'hCAFE_F00D;
        step("zero_dst");

        // Flush beats stall; count five consecutive bubbles from a clean reset.
        async_reset("rst2");
        en = 0; flush = 1;
        for (int i = 0; i < 5; i++) begin
            drive_random();
            step("flush");
        end
`ifdef EM_BUBBLE_CNT_EN
        check_eq("flush.cnt5", M_bubble_cnt, 32'd5);
`else
        check_eq("flush.cnt0", M_bubble_cnt, 32'd0);
`endif

        // Reset while mid-flush.
        async_reset("rst_flush");

        // Randomized traffic with occasional async resets.
        flush = 0;
        for (int i = 0; i < 400; i++) begin
            drive_random();
            en = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 40) == 0) begin
                async_reset("rnd_rst");
            end
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
